// File: rtl/iq_free_list_if.sv
// Free-list port bundle between the dispatch stage and the issue-queue free list.
//   master : dispatch/issue side. It drives the requests, the releases and the flush.
//   slave  : the free list. It returns the allocated indices, the write enables, the stall,
//            the free count and the error flag.
interface iq_free_list_if #(
  parameter int unsigned INDEX          = 5,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned ISSUE_WIDTH    = 4
);
  logic                            flush_i;
  logic [DISPATCH_WIDTH-1:0]       dispatch_req_i;
  logic [DISPATCH_WIDTH*INDEX-1:0] alloc_idx_o;
  logic [DISPATCH_WIDTH-1:0]       alloc_we_o;
  logic                            stall_o;
  logic [ISSUE_WIDTH-1:0]          free_valid_i;
  logic [ISSUE_WIDTH*INDEX-1:0]    free_idx_i;
  logic [INDEX:0]                  free_cnt_o;
  logic                            err_o;

  modport master (
    output flush_i, dispatch_req_i, free_valid_i, free_idx_i,
    input  alloc_idx_o, alloc_we_o, stall_o, free_cnt_o, err_o
  );

  modport slave (
    input  flush_i, dispatch_req_i, free_valid_i, free_idx_i,
    output alloc_idx_o, alloc_we_o, stall_o, free_cnt_o, err_o
  );
endinterface

// File: rtl/iq_free_list.sv
// Issue-queue free list. It is a circular FIFO of free entry indices.
// Dispatch lanes pop at the head with zero latency. Issue lanes push released indices at the
// tail, compacted in ascending lane order.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   fl (slave)   : flush, dispatch requests and indices, write enables, stall,
//                  release lanes, free count and error flag
// Optional macro IQ_FREELIST_CHECK_EN adds a busy vector and a sticky error flag for
// double frees, duplicate releases, count overflow and non-contiguous requests.
// When the macro is undefined, err_o is tied to 0.
module iq_free_list #(
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned INDEX          = 5,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned ISSUE_WIDTH    = 4
) (
  input logic           clk,
  input logic           reset_n,
  iq_free_list_if.slave fl
);
  localparam int unsigned CntW = INDEX + 1;
  typedef logic [INDEX-1:0] idx_t;
  typedef logic [CntW-1:0]  cnt_t;

  idx_t fifo_q [DEPTH];
  idx_t fifo_d [DEPTH];
  idx_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;
  cnt_t n_alloc, n_free, alloc_cnt;
  logic stall, alloc_go;
  idx_t alloc_idx [DISPATCH_WIDTH];

  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) n_alloc = n_alloc + cnt_t'(fl.dispatch_req_i[k]);
  end

  // Stall and the indices depend only on registered state, so same-cycle releases never
  // become allocatable before the next edge.
  assign stall     = count_q < n_alloc;
  assign alloc_go  = ~stall & ~fl.flush_i;
  assign alloc_cnt = alloc_go ? n_alloc : '0;

  always_comb begin
    fl.alloc_idx_o = '0;
    fl.alloc_we_o  = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      alloc_idx[k]                   = fifo_q[head_q + idx_t'(k)];
      fl.alloc_idx_o[k*INDEX +: INDEX] = alloc_idx[k];
      fl.alloc_we_o[k]               = fl.dispatch_req_i[k] & alloc_go;
    end
  end

  assign fl.stall_o    = stall;
  assign fl.free_cnt_o = count_q;

  always_comb begin
    fifo_d = fifo_q;
    n_free = '0;
    // Compact the valid release lanes onto consecutive slots starting at the tail.
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (fl.free_valid_i[k]) begin
        fifo_d[tail_q + idx_t'(n_free)] = fl.free_idx_i[k*INDEX +: INDEX];
        n_free = n_free + cnt_t'(1);
      end
    end
    head_d  = head_q + idx_t'(alloc_cnt);
    tail_d  = tail_q + idx_t'(n_free);
    count_d = count_q - alloc_cnt + n_free;
    if (fl.flush_i) begin
      for (int i = 0; i < DEPTH; i++) fifo_d[i] = idx_t'(i);
      head_d  = '0;
      tail_d  = '0;
      count_d = cnt_t'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= idx_t'(i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= cnt_t'(DEPTH);
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef IQ_FREELIST_CHECK_EN
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             dbl_free, dup_free, overflow, noncontig;
  logic [CntW:0]    cnt_sum;

  always_comb begin
    busy_d    = busy_q;
    dbl_free  = 1'b0;
    dup_free  = 1'b0;
    noncontig = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (fl.free_valid_i[k]) begin
        if (!busy_q[fl.free_idx_i[k*INDEX +: INDEX]]) dbl_free = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (fl.free_valid_i[j] &&
              fl.free_idx_i[j*INDEX +: INDEX] == fl.free_idx_i[k*INDEX +: INDEX]) begin
            dup_free = 1'b1;
          end
        end
        busy_d[fl.free_idx_i[k*INDEX +: INDEX]] = 1'b0;
      end
    end
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (fl.alloc_we_o[k]) busy_d[alloc_idx[k]] = 1'b1;
    end
    for (int k = 1; k < DISPATCH_WIDTH; k++) begin
      if (fl.dispatch_req_i[k] && !fl.dispatch_req_i[k-1]) noncontig = 1'b1;
    end
    // Compare count + nF against DEPTH + allocated to avoid an underflowing subtraction.
    cnt_sum  = {1'b0, count_q} + {1'b0, n_free};
    overflow = cnt_sum > ({1'b0, alloc_cnt} + (CntW+1)'(DEPTH));
    err_d    = err_q | dbl_free | dup_free | overflow | noncontig;
    if (fl.flush_i) begin
      busy_d = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign fl.err_o = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && !fl.flush_i) begin
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (fl.free_valid_i[k] && !busy_q[fl.free_idx_i[k*INDEX +: INDEX]]) begin
          $error("iq_free_list: double free of index %0d on lane %0d",
                 fl.free_idx_i[k*INDEX +: INDEX], k);
        end
      end
      if (dup_free) $error("iq_free_list: same index released on two lanes");
      if (overflow) $error("iq_free_list: free count overflow");
      if (noncontig) $error("iq_free_list: non-contiguous dispatch request %b",
                            fl.dispatch_req_i);
    end
  end
`endif
`else
  assign fl.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_iq_free_list.sv
module tb_iq_free_list;
  localparam logic [3:0] F = 4'b1111;
`ifdef IQ_FREELIST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  iq_free_list_if #(.INDEX(5), .DISPATCH_WIDTH(4), .ISSUE_WIDTH(4)) fl_if ();

  iq_free_list #(.DEPTH(32), .INDEX(5), .DISPATCH_WIDTH(4), .ISSUE_WIDTH(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fl      (fl_if)
  );

  typedef struct {
    string       name;
    logic [19:0] idx;
    logic [3:0]  idx_mask;
    logic [3:0]  we;
    logic        stall;
    logic [5:0]  cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_err  = 1'b0;

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [19:0] m;
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) m[k*5 +: 5] = {5{e.idx_mask[k]}};
      n_checks++;
      if (((fl_if.alloc_idx_o & m) != (e.idx & m)) || fl_if.alloc_we_o !== e.we ||
          fl_if.stall_o !== e.stall || fl_if.free_cnt_o !== e.cnt || fl_if.err_o !== e.err) begin
        n_errors++;
        $display("FAIL %s: got idx=%h we=%b stall=%b cnt=%0d err=%b, want idx=%h(mask %b) we=%b stall=%b cnt=%0d err=%b",
                 e.name, fl_if.alloc_idx_o, fl_if.alloc_we_o, fl_if.stall_o, fl_if.free_cnt_o,
                 fl_if.err_o, e.idx, e.idx_mask, e.we, e.stall, e.cnt, e.err);
      end
    end
  end

  task automatic step(input string nm, input logic [3:0] req, input logic [3:0] fv,
                      input logic [19:0] fidx, input logic flush, input logic [19:0] e_idx,
                      input logic [3:0] e_mask, input logic [3:0] e_we, input logic e_stall,
                      input logic [5:0] e_cnt);
    exp_t e;
    fl_if.dispatch_req_i = req;
    fl_if.free_valid_i   = fv;
    fl_if.free_idx_i     = fidx;
    fl_if.flush_i        = flush;
    e.name = nm; e.idx = e_idx; e.idx_mask = e_mask; e.we = e_we;
    e.stall = e_stall; e.cnt = e_cnt; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Reset pulsed low between edges; the sample falls while reset is still asserted.
  task automatic rst_step(input string nm);
    exp_t e;
    fl_if.dispatch_req_i = '0;
    fl_if.free_valid_i   = '0;
    fl_if.free_idx_i     = '0;
    fl_if.flush_i        = 1'b0;
    reset_n              = 1'b0;
    e.name = nm; e.idx = pk(0, 1, 2, 3); e.idx_mask = F; e.we = '0;
    e.stall = 1'b0; e.cnt = 6'd32; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n              = 1'b0;
    fl_if.dispatch_req_i = '0;
    fl_if.free_valid_i   = '0;
    fl_if.free_idx_i     = '0;
    fl_if.flush_i        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state, then drain the list four entries at a time.
    step("reset", 0, 0, 0, 0, pk(0, 1, 2, 3), F, 0, 0, 32);
    for (int j = 0; j < 8; j++)
      step("fill", F, 0, 0, 0, pk(4*j, 4*j+1, 4*j+2, 4*j+3), F, F, 0, 6'(32 - 4*j));
    step("fill_stall", F, 0, 0, 0, pk(0, 1, 2, 3), F, 0, 1, 0);

    // Release from empty on lanes 0 and 2; compaction puts 9 before 5.
    step("rel_two", 0, 4'b0101, pk(9, 0, 5, 0), 0, 0, 0, 0, 0, 0);
    step("stall_3of2", 4'b0111, 0, 0, 0, pk(9, 5, 0, 0), 4'b0011, 0, 1, 2);
    step("alloc_2", 4'b0011, 0, 0, 0, pk(9, 5, 0, 0), 4'b0011, 4'b0011, 0, 2);

    // A same-cycle allocation and release; the released entries come out a cycle later.
    step("rel_three", 0, 4'b0111, pk(9, 5, 20, 0), 0, pk(2, 3, 4, 5), F, 0, 0, 0);
    step("alloc_rel", 4'b0111, 4'b0011, pk(11, 12, 0, 0), 0, pk(9, 5, 20, 0), 4'b0111,
         4'b0111, 0, 3);
    step("late_alloc", 4'b0011, 0, 0, 0, pk(11, 12, 0, 0), 4'b0011, 4'b0011, 0, 2);

    // Walk the head from 7 to 30, then allocate across the wrap.
    step("seed", 0, F, pk(0, 1, 2, 3), 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step("cycle", F, F, pk(4*i, 4*i+1, 4*i+2, 4*i+3), 0,
           pk(4*i-4, 4*i-3, 4*i-2, 4*i-1), F, F, 0, 4);
    step("to_30", 4'b0111, 4'b0111, pk(24, 25, 26, 0), 0, pk(20, 21, 22, 0), 4'b0111,
         4'b0111, 0, 4);
    step("wrap", F, 0, 0, 0, pk(23, 24, 25, 26), F, F, 0, 4);
    step("head_2", 0, 0, 0, 0, pk(9, 5, 20, 11), F, 0, 0, 0);

    // Flush with traffic active at count 10.
    step("pre1", 0, F, pk(27, 28, 29, 30), 0, 0, 0, 0, 0, 0);
    step("pre2", 0, F, pk(31, 0, 1, 2), 0, 0, 0, 0, 0, 4);
    step("pre3", 0, 4'b0011, pk(3, 4, 0, 0), 0, 0, 0, 0, 0, 8);
    step("flush", F, F, pk(5, 6, 7, 8), 1, pk(27, 28, 29, 30), F, 0, 0, 10);
    step("post_flush", 0, 0, 0, 0, pk(0, 1, 2, 3), F, 0, 0, 32);
    step("refill_a", F, 0, 0, 0, pk(0, 1, 2, 3), F, F, 0, 32);
    step("refill_b", F, 0, 0, 0, pk(4, 5, 6, 7), F, F, 0, 28);
    rst_step("rst_async");
    step("post_rst", F, 0, 0, 0, pk(0, 1, 2, 3), F, F, 0, 32);

    // Release index 7 while it is still free.
    step("free_free", 0, 4'b0001, pk(7, 0, 0, 0), 0, 0, 0, 0, 0, 28);
    exp_err = CHK;
    step("err_set", 0, 0, 0, 0, 0, 0, 0, 0, 29);
    step("err_hold", 0, 0, 0, 0, 0, 0, 0, 0, 29);
    step("err_flush", 0, 0, 0, 1, 0, 0, 0, 0, 29);
    exp_err = 1'b0;
    step("err_clr", 0, 0, 0, 0, pk(0, 1, 2, 3), F, 0, 0, 32);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected records left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/iq_free_list.md
Name: iq_free_list

Overview:
Allocates issue-queue entry indices at dispatch and reclaims them at issue. It supplies the write addresses and write enables for the IQ payload RAM and the IQ wakeup/select arrays. It is a circular FIFO of free entry indices: dispatch lanes pop at the head, issue lanes push at the tail. It sits in the dispatch stage, directly upstream of the IQ payload write ports.

Parameters:
DEPTH, 32, number of IQ entries (power of 2)
INDEX, 5, log2(DEPTH); entry index width
DISPATCH_WIDTH, 4, allocation lanes per cycle
ISSUE_WIDTH, 4, release lanes per cycle

Ports:
clk  input  1  clock; all state on posedge
reset_n  input  1  asynchronous active-low reset
flush_i  input  1  synchronous recovery; returns every entry to the free state
dispatch_req_i  input  DISPATCH_WIDTH  per-lane allocation request; set lanes contiguous from lane 0
alloc_idx_o  output  DISPATCH_WIDTH*INDEX  lane k index = fifo[head+k], combinational from registered state
alloc_we_o  output  DISPATCH_WIDTH  dispatch_req_i[k] & ~stall_o; drives payload RAM weK
stall_o  output  1  free_cnt_o < popcount(dispatch_req_i)
free_valid_i  input  ISSUE_WIDTH  per-lane release valid, any pattern
free_idx_i  input  ISSUE_WIDTH*INDEX  index released by lane k
free_cnt_o  output  INDEX+1  registered count of free entries
err_o  output  1  sticky error flag (see Optional Feature)

Behaviour:
- State: fifo[DEPTH] of INDEX bits, head and tail pointers of INDEX bits, count of INDEX+1 bits.
- Reset (async, reset_n=0): fifo[i]=i, head=0, tail=0, count=DEPTH. Outputs after reset: free_cnt_o=DEPTH, stall_o=0 with no requests, alloc_idx_o lane k = k, alloc_we_o=0, err_o=0.
- Allocation: nA = popcount(dispatch_req_i).
  - If stall_o=0: head <= head+nA (mod DEPTH). Indices are visible the same cycle; there is zero latency between request and index.
  - If stall_o=1: nothing is allocated, all alloc_we_o are 0, and head is unchanged. Allocation is all-or-nothing; there is no partial allocation.
- Release: valid lanes are compacted in ascending lane order and written to fifo[tail], fifo[tail+1], and so on. tail <= tail + popcount(free_valid_i) (mod DEPTH).
- Count: count <= count - (stall_o ? 0 : nA) + nF.
- Same-cycle release and allocation: entries released this cycle are not allocatable until the next cycle, because stall and the indices use registered count and head.
- Full (count=DEPTH): tail equals head; a release in this state is illegal.
- Empty (count=0): any request stalls, and releases proceed normally.
- Pointer wrap: all pointer and slot arithmetic is modulo DEPTH. Lane slots head+k wrap past DEPTH-1 to 0.
- flush_i=1: on the next edge, state equals the reset state (fifo[i]=i, head=tail=0, count=DEPTH). flush_i overrides same-cycle allocations and releases, and alloc_we_o is forced to 0 during flush.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronously). The first edge after deassertion behaves like the first cycle after reset.
- err_o is tied to 0 unless the optional feature is compiled in.

Optional Feature:
IQ_FREELIST_CHECK_EN.
- When defined, add a DEPTH-bit busy vector: set on allocation, cleared on release, all zeros on reset and flush.
- err_o is sticky (cleared only by reset or flush) and is set the cycle after any of these:
  - a release of an index whose busy bit is 0 (double free);
  - two lanes releasing the same index in one cycle;
  - count + nF - allocated > DEPTH;
  - dispatch_req_i lanes not contiguous from lane 0.
- Under simulation the block also prints $error with the index and lane.
- When undefined, there is no busy vector and err_o=0 constantly.

Test Plan:
1. Reset then dispatch_req_i=4'b1111 for 8 cycles -> alloc_idx_o {0,1,2,3}, {4,5,6,7}, ..., {28,29,30,31}; free_cnt_o 32, 28, ..., 0; the 9th request gives stall_o=1 and alloc_we_o=0.
2. Empty; release idx 5 and 9 on lanes 2 and 0 (both valid) -> next cycle free_cnt_o=2, fifo holds 9 then 5; dispatch_req_i=4'b0011 -> alloc_idx_o {9,5}; dispatch_req_i=4'b0111 -> stall_o=1.
3. count=3 with requests 4'b0111 and 2 releases in the same cycle -> no stall, three allocated; next free_cnt_o=2; the released indices are allocated only in a later cycle.
4. Drive head to 30 via allocate/release cycling, then request 4 -> alloc lanes read slots 30, 31, 0, 1 and head=2.
5. Mid-stream (count=10, nonzero pointers): flush_i=1 with requests and releases active -> alloc_we_o=0; next cycle free_cnt_o=32 and alloc_idx_o {0,1,2,3}. Repeating with reset_n pulsed low between edges gives the same state immediately.
6. With IQ_FREELIST_CHECK_EN: release idx 7 while it is free -> err_o=1 next cycle and stays 1 until flush_i. Without the macro the same stimulus leaves err_o=0.
